wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Writeback arbiter that sits directly upstream of the register file and drives its single write port (write_en, write_imm, waddr, data_in).
- Merges two result sources:
  - the single-cycle ALU, which has no backpressure and priority;
  - the multi-cycle load unit, which uses a valid/ready handshake and is buffered in an in-order FIFO.
- Gives decode a pending-write check for load-use stalls and a starvation stall so loads always drain.

Parameters:
W, 8, data path width (matches register file W)
D, 3, register address width (matches register file D)
DEPTH, 2, load FIFO entries (>=1)
STARVE, 4, cycles a FIFO head may wait before ALU is locked out (>=1)

Ports:
CLK  in  1  clock, all state on rising edge
RST_N  in  1  synchronous active-low reset
alu_valid  in  1  ALU result present this cycle
alu_waddr  in  D  ALU destination register
alu_data  in  W  ALU result
alu_imm  in  1  ALU result targets RIM (reserved immediate register)
ld_valid  in  1  load result offered
ld_ready  out  1  arbiter accepts load this cycle
ld_waddr  in  D  load destination register
ld_data  in  W  load data
write_en  out  1  register file write enable
write_imm  out  1  register file RIM select
waddr  out  D  register file write address
data_in  out  W  register file write data
ld_pending  out  1  FIFO non-empty
chk_addr  in  D  decode source register to check
chk_hit  out  1  a queued or in-flight load targets chk_addr
alu_stall  out  1  decode must not issue ALU op this cycle
alu_drop  out  1  one-cycle pulse: ALU result discarded (protocol violation)

Behaviour:
- Reset (RST_N=0 at a CLK edge):
  - write_en=0, write_imm=0, waddr=0, data_in=0, alu_drop=0;
  - FIFO emptied and age counter cleared.
  - ld_ready is forced 0 while RST_N=0; all other outputs follow the cleared state.
- Write port outputs are registered: a result selected in cycle N appears on write_en/waddr/data_in in cycle N+1 for exactly one cycle. Fixed latency is 1 cycle.
- ld_ready = RST_N && (count < DEPTH). It depends only on registered count, never on same-cycle pops. When full, ld_ready=0 even if a pop occurs.
- A load is accepted when ld_valid && ld_ready.
- Selection each cycle, in priority order:
  1. If alu_stall=1 and the FIFO is non-empty: pop the FIFO head to the output. If alu_valid=1 as well, discard the ALU result and pulse alu_drop next cycle.
  2. Else if alu_valid=1: output the ALU result. write_imm=alu_imm; when alu_imm=1, waddr is driven 0.
  3. Else if the FIFO is non-empty: pop the head to the output (write_imm=0).
  4. Else if a load is accepted this cycle: bypass it straight to the output; it does not enter the FIFO.
  5. Else: write_en=0 next cycle; waddr/data_in hold their last values.
- An accepted load not bypassed is pushed to the FIFO tail. A push and pop in the same cycle is legal; count is unchanged.
- Loads retire strictly in acceptance order. Loads never set write_imm.
- Age counter (range 0..STARVE):
  - cleared when the FIFO is empty or the head pops;
  - otherwise increments, saturating at STARVE.
- alu_stall = (age == STARVE), combinational from the register. It is asserted for exactly the cycle in which the head is force-popped.
- chk_hit (combinational) = 1 if any valid FIFO entry's waddr == chk_addr, OR (write_en && !write_imm && waddr == chk_addr).
- Write-after-write ordering between ALU and older loads to the same register is decode's responsibility, enforced via chk_hit.
- Pointers wrap modulo DEPTH; count spans 0..DEPTH.
- Reset asserted mid-operation discards all queued loads and any in-flight write: write_en=0 the following cycle.

Test Plan:
1. Reset, then a single load (ld_waddr=3, ld_data=0x5A) with no ALU -> ld_ready=1, bypass; the next cycle write_en=1, waddr=3, data_in=0x5A; FIFO stays empty.
2. ALU (waddr=2, data=0x11) and load (waddr=4, data=0x22) in the same cycle -> cycle+1 writes r2=0x11; cycle+2 writes r4=0x22; chk_addr=4 gives chk_hit=1 until the r4 write cycle ends.
3. DEPTH=2: three back-to-back loads with ALU busy every cycle -> ld_ready drops to 0 after two accepts; the third is held until count<2; order r-a, r-b, r-c is preserved.
4. STARVE=4: FIFO holds one load, alu_valid=1 continuously -> alu_stall=1 on the 5th cycle, the load is written the next cycle, and alu_drop pulses once for the discarded ALU result.
5. alu_imm=1 (data=0xC3, alu_waddr=5) -> write_en=1, write_imm=1, waddr=0, data_in=0xC3; chk_addr=5 gives chk_hit=0.
6. Two loads queued, then RST_N=0 for one cycle -> the next cycle has write_en=0, ld_pending=0, ld_ready=1 once RST_N=1, and no queued write ever appears.

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback arbiter that drives the register file write port. ALU results have priority;
// load results wait in an in-order FIFO, which a starvation counter eventually forces out.
module wb_arbiter #(
  parameter int unsigned W      = 8,
  parameter int unsigned D      = 3,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned STARVE = 4
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         alu_valid,
  input  logic [D-1:0] alu_waddr,
  input  logic [W-1:0] alu_data,
  input  logic         alu_imm,
  input  logic         ld_valid,
  output logic         ld_ready,
  input  logic [D-1:0] ld_waddr,
  input  logic [W-1:0] ld_data,
  output logic         write_en,
  output logic         write_imm,
  output logic [D-1:0] waddr,
  output logic [W-1:0] data_in,
  output logic         ld_pending,
  input  logic [D-1:0] chk_addr,
  output logic         chk_hit,
  output logic         alu_stall,
  output logic         alu_drop
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(STARVE + 1);

  logic [D-1:0]     fifo_addr_q [DEPTH];
  logic [W-1:0]     fifo_data_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [AW-1:0]    age_q, age_d;

  logic         write_en_q, write_imm_q, drop_q;
  logic [D-1:0] waddr_q;
  logic [W-1:0] data_q;

  logic         fifo_ne, accept, pop, push, bypass;
  logic         sel_en, sel_imm, drop_d;
  logic [D-1:0] sel_addr;
  logic [W-1:0] sel_data;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign fifo_ne    = (count_q != '0);
  assign ld_pending = fifo_ne;
  assign alu_stall  = (age_q == AW'(STARVE));
  // Based on registered occupancy only, so a same-cycle pop never frees a slot early.
  assign ld_ready   = RST_N && (count_q < CW'(DEPTH));
  assign accept     = ld_valid && ld_ready;

  always_comb begin
    pop      = 1'b0;
    bypass   = 1'b0;
    sel_en   = 1'b0;
    sel_imm  = 1'b0;
    sel_addr = waddr_q;
    sel_data = data_q;
    drop_d   = 1'b0;
    if (alu_stall && fifo_ne) begin
      pop    = 1'b1;
      drop_d = alu_valid;
    end else if (alu_valid) begin
      sel_en   = 1'b1;
      sel_imm  = alu_imm;
      sel_addr = alu_imm ? '0 : alu_waddr;
      sel_data = alu_data;
    end else if (fifo_ne) begin
      pop = 1'b1;
    end else if (accept) begin
      bypass   = 1'b1;
      sel_en   = 1'b1;
      sel_addr = ld_waddr;
      sel_data = ld_data;
    end
    if (pop) begin
      sel_en   = 1'b1;
      sel_addr = fifo_addr_q[rd_ptr_q];
      sel_data = fifo_data_q[rd_ptr_q];
    end
  end

  assign push = accept && !bypass;

  always_comb begin
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    vld_d    = vld_q;
    if (pop)  vld_d[rd_ptr_q] = 1'b0;
    if (push) vld_d[wr_ptr_q] = 1'b1;
    count_d = count_q;
    if (push && !pop) count_d = count_q + CW'(1);
    if (pop && !push) count_d = count_q - CW'(1);
    age_d = age_q;
    if (!fifo_ne || pop)            age_d = '0;
    else if (age_q != AW'(STARVE)) age_d = age_q + AW'(1);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      vld_q       <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      age_q       <= '0;
      write_en_q  <= 1'b0;
      write_imm_q <= 1'b0;
      waddr_q     <= '0;
      data_q      <= '0;
      drop_q      <= 1'b0;
    end else begin
      vld_q       <= vld_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      age_q       <= age_d;
      write_en_q  <= sel_en;
      write_imm_q <= sel_imm;
      waddr_q     <= sel_addr;
      data_q      <= sel_data;
      drop_q      <= drop_d;
    end
  end

  // Payload storage needs no reset; validity is tracked by vld_q.
  always_ff @(posedge CLK) begin
    if (RST_N && push) begin
      fifo_addr_q[wr_ptr_q] <= ld_waddr;
      fifo_data_q[wr_ptr_q] <= ld_data;
    end
  end

  always_comb begin
    chk_hit = write_en_q && !write_imm_q && (waddr_q == chk_addr);
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (fifo_addr_q[i] == chk_addr)) chk_hit = 1'b1;
    end
  end

  assign write_en  = write_en_q;
  assign write_imm = write_imm_q;
  assign waddr     = waddr_q;
  assign data_in   = data_q;
  assign alu_drop  = drop_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus random traffic, every cycle compared against
// a queue-based model of the arbitration rules.
module tb_wb_arbiter;
  localparam int W = 8, D = 3, DEPTH = 2, STARVE = 4;

  logic         CLK = 1'b0, RST_N = 1'b0;
  logic         alu_valid, alu_imm, ld_valid, ld_ready;
  logic [D-1:0] alu_waddr, ld_waddr, waddr, chk_addr;
  logic [W-1:0] alu_data, ld_data, data_in;
  logic         write_en, write_imm, ld_pending, chk_hit, alu_stall, alu_drop;

  always #5 CLK = ~CLK;

  wb_arbiter #(.W(W), .D(D), .DEPTH(DEPTH), .STARVE(STARVE)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .alu_valid(alu_valid), .alu_waddr(alu_waddr), .alu_data(alu_data), .alu_imm(alu_imm),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_waddr(ld_waddr), .ld_data(ld_data),
    .write_en(write_en), .write_imm(write_imm), .waddr(waddr), .data_in(data_in),
    .ld_pending(ld_pending), .chk_addr(chk_addr), .chk_hit(chk_hit),
    .alu_stall(alu_stall), .alu_drop(alu_drop)
  );

  typedef struct packed {logic [D-1:0] a; logic [W-1:0] d;} ld_t;

  ld_t          q[$];
  int           age = 0;
  logic         m_we = 0, m_imm = 0, m_drop = 0;
  logic [D-1:0] m_waddr = '0;
  logic [W-1:0] m_data = '0;
  bit           m_acc;
  int           checks = 0, passed = 0, fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    alu_valid = 0; alu_imm = 0; ld_valid = 0;
    alu_waddr = '0; alu_data = '0; ld_waddr = '0; ld_data = '0;
  endtask

  // One clock: check combinational outputs, advance the model, check the registered outputs.
  task automatic step();
    bit ready, stall, hit, pop, byp, was_empty;
    ld_t h;
    #1;
    ready = RST_N && (q.size() < DEPTH);
    stall = (age == STARVE);
    hit = (m_we && !m_imm && m_waddr == chk_addr);
    foreach (q[i]) if (q[i].a == chk_addr) hit = 1;
    chk("ld_ready", ld_ready, ready);
    chk("alu_stall", alu_stall, stall);
    chk("ld_pending", ld_pending, q.size() != 0);
    chk("chk_hit", chk_hit, hit);
    m_acc = ld_valid && ready;
    if (!RST_N) begin
      q.delete(); age = 0;
      m_we = 0; m_imm = 0; m_waddr = '0; m_data = '0; m_drop = 0;
    end else begin
      was_empty = (q.size() == 0);
      pop = 0; byp = 0; m_drop = 0; m_we = 1; m_imm = 0;
      if (stall && !was_empty) begin
        h = q.pop_front(); pop = 1; m_drop = alu_valid;
      end else if (alu_valid) begin
        m_imm = alu_imm; m_waddr = alu_imm ? '0 : alu_waddr; m_data = alu_data;
      end else if (!was_empty) begin
        h = q.pop_front(); pop = 1;
      end else if (m_acc) begin
        byp = 1; m_waddr = ld_waddr; m_data = ld_data;
      end else begin
        m_we = 0;
      end
      if (pop) begin m_waddr = h.a; m_data = h.d; end
      if (m_acc && !byp) q.push_back(ld_t'({ld_waddr, ld_data}));
      age = (was_empty || pop) ? 0 : ((age < STARVE) ? age + 1 : STARVE);
    end
    @(posedge CLK); #1;
    chk("write_en", write_en, m_we);
    chk("write_imm", write_imm, m_imm);
    chk("waddr", waddr, m_waddr);
    chk("data_in", data_in, m_data);
    chk("alu_drop", alu_drop, m_drop);
  endtask

  initial begin
    logic [D-1:0] la [3];
    logic [W-1:0] ldat [3];
    logic [W-1:0] seen [$];
    int li, drops;

    idle(); chk_addr = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_write_en", write_en, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_data_in", data_in, 0);
    chk("rst_ld_ready", ld_ready, 0);
    RST_N = 1;

    // Single load bypasses straight to the port.
    ld_valid = 1; ld_waddr = 3; ld_data = 8'h5A;
    step();
    idle();
    chk("t1_we", write_en, 1);
    chk("t1_waddr", waddr, 3);
    chk("t1_data", data_in, 8'h5A);
    chk("t1_pending", ld_pending, 0);
    step();

    // ALU and load together: ALU first, load next cycle.
    alu_valid = 1; alu_waddr = 2; alu_data = 8'h11;
    ld_valid = 1; ld_waddr = 4; ld_data = 8'h22; chk_addr = 4;
    step();
    idle();
    chk("t2_waddr0", waddr, 2);
    chk("t2_data0", data_in, 8'h11);
    chk("t2_hit0", chk_hit, 1);
    step();
    chk("t2_waddr1", waddr, 4);
    chk("t2_data1", data_in, 8'h22);
    chk("t2_hit1", chk_hit, 1);
    step();
    chk("t2_hit2", chk_hit, 0);

    // Three loads against a constantly busy ALU: backpressure and ordering.
    la[0] = 1; la[1] = 5; la[2] = 6;
    ldat[0] = 8'hA1; ldat[1] = 8'hB2; ldat[2] = 8'hC3;
    li = 0;
    for (int cyc = 0; cyc < 40 && seen.size() < 3; cyc++) begin
      alu_valid = 1; alu_waddr = 7; alu_data = W'($urandom_range(0, 15));
      ld_valid = (li < 3);
      ld_waddr = la[li < 3 ? li : 0]; ld_data = ldat[li < 3 ? li : 0];
      step();
      if (m_acc) li++;
      if (write_en && waddr != 7) seen.push_back(data_in);
    end
    chk("t3_accepted", li, 3);
    chk("t3_count", seen.size(), 3);
    for (int i = 0; i < 3; i++) chk("t3_order", (i < seen.size()) ? seen[i] : 8'hXX, ldat[i]);
    idle();
    repeat (4) step();

    // One queued load starved by the ALU until the forced pop.
    alu_valid = 1; alu_waddr = 1; alu_data = 8'h0F;
    ld_valid = 1; ld_waddr = 2; ld_data = 8'h44;
    step();
    ld_valid = 0;
    drops = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      if (alu_drop) drops++;
    end
    chk("t4_drops", drops, 1);
    idle();
    step();

    // ALU write to the reserved immediate register.
    alu_valid = 1; alu_imm = 1; alu_waddr = 5; alu_data = 8'hC3; chk_addr = 5;
    step();
    idle();
    chk("t5_we", write_en, 1);
    chk("t5_imm", write_imm, 1);
    chk("t5_waddr", waddr, 0);
    chk("t5_data", data_in, 8'hC3);
    chk("t5_hit", chk_hit, 0);
    step();

    // Reset while two loads are queued.
    alu_valid = 1; alu_waddr = 3; alu_data = 8'h01;
    ld_valid = 1; ld_waddr = 6; ld_data = 8'h66;
    step();
    ld_waddr = 7; ld_data = 8'h77;
    step();
    idle();
    RST_N = 0;
    step();
    chk("t6_we", write_en, 0);
    chk("t6_pending", ld_pending, 0);
    RST_N = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t6_no_write", write_en, 0);
    end

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      RST_N     = ($urandom_range(0, 49) != 0);
      alu_valid = $urandom_range(0, 1) == 1;
      alu_imm   = $urandom_range(0, 7) == 0;
      alu_waddr = D'($urandom); alu_data = W'($urandom);
      ld_valid  = $urandom_range(0, 1) == 1;
      ld_waddr  = D'($urandom); ld_data = W'($urandom);
      chk_addr  = D'($urandom);
      step();
    end
    RST_N = 1;
    idle();
    repeat (3) step();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
